// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: valid/ready handshake, 2-entry skid buffer, flush, retire counter.
// Optional operand forwarding taps from the main entry when MEM_WB_FWD_EN is defined.
module mem_wb_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int MEMTOREG_W = 2,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_load_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [REG_W-1:0]      in_dest_reg,
  input  logic                  in_reg_write,
  input  logic [MEMTOREG_W-1:0] in_mem_to_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_load_data,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [REG_W-1:0]      out_dest_reg,
  output logic                  out_reg_write,
  output logic [MEMTOREG_W-1:0] out_mem_to_reg,
`ifdef MEM_WB_FWD_EN
  input  logic [REG_W-1:0]      fwd_rs,
  input  logic [REG_W-1:0]      fwd_rt,
  output logic                  fwd_rs_hit,
  output logic                  fwd_rt_hit,
  output logic [DATA_W-1:0]     fwd_rs_data,
  output logic [DATA_W-1:0]     fwd_rt_data,
`endif
  output logic [CNT_W-1:0]      retire_count
);

  typedef struct packed {
    logic [DATA_W-1:0]     loadData;
    logic [DATA_W-1:0]     aluResult;
    logic [REG_W-1:0]      destReg;
    logic                  regWrite;
    logic [MEMTOREG_W-1:0] memToReg;
  } beat_t;

  // State is the pair {mainValid, skidValid}.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  beat_t            mainQ, skidQ, inBeat;
  logic             mainValid, skidValid, inReadyQ;
  logic             accept, drain;
  logic [CNT_W-1:0] retireCnt;

  assign inBeat = '{loadData: in_load_data, aluResult: in_alu_result, destReg: in_dest_reg,
                    regWrite: in_reg_write, memToReg: in_mem_to_reg};

  assign accept = in_valid & inReadyQ;
  assign drain  = mainValid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      inReadyQ  <= 1'b1;
      mainQ     <= '0;
      skidQ     <= '0;
      retireCnt <= '0;
    end else begin
      // A drain completes even in a flush cycle, so it is counted unconditionally.
      if (drain && mainQ.regWrite) retireCnt <= retireCnt + CNT_W'(1);
      if (flush) begin
        mainValid <= 1'b0;
        skidValid <= 1'b0;
        inReadyQ  <= 1'b1;
      end else begin
        case ({mainValid, skidValid})
          EMPTY: if (accept) begin
            mainQ     <= inBeat;
            mainValid <= 1'b1;
          end
          ONE: begin
            if (accept && drain) begin
              mainQ <= inBeat;
            end else if (accept) begin
              skidQ     <= inBeat;
              skidValid <= 1'b1;
              inReadyQ  <= 1'b0;
            end else if (drain) begin
              mainValid <= 1'b0;
            end
          end
          FULL: if (drain) begin
            mainQ     <= skidQ;
            skidValid <= 1'b0;
            inReadyQ  <= 1'b1;
          end
          default: begin
            // Unreachable encoding: fall back to empty.
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            inReadyQ  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready       = inReadyQ;
  assign out_valid      = mainValid;
  assign out_load_data  = mainQ.loadData;
  assign out_alu_result = mainQ.aluResult;
  assign out_dest_reg   = mainQ.destReg;
  assign out_reg_write  = mainQ.regWrite & mainValid;
  assign out_mem_to_reg = mainQ.memToReg;
  assign retire_count   = retireCnt;

`ifdef MEM_WB_FWD_EN
  logic [DATA_W-1:0] fwdData;
  logic              fwdLive;
  assign fwdData     = (mainQ.memToReg == MEMTOREG_W'(1)) ? mainQ.loadData : mainQ.aluResult;
  assign fwdLive     = out_reg_write & (mainQ.destReg != '0);
  assign fwd_rs_hit  = fwdLive & (mainQ.destReg == fwd_rs);
  assign fwd_rt_hit  = fwdLive & (mainQ.destReg == fwd_rt);
  assign fwd_rs_data = fwdData;
  assign fwd_rt_data = fwdData;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_wb_pipe_reg;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_reg_write, in_reg_write = 1'b0;
  logic [31:0] in_load_data = '0, in_alu_result = '0, out_load_data, out_alu_result;
  logic [4:0]  in_dest_reg = '0, out_dest_reg;
  logic [1:0]  in_mem_to_reg = '0, out_mem_to_reg;
  logic [31:0] retire_count;
`ifdef MEM_WB_FWD_EN
  logic [4:0]  fwd_rs = '0, fwd_rt = '0;
  logic        fwd_rs_hit, fwd_rt_hit;
  logic [31:0] fwd_rs_data, fwd_rt_data;
`endif

  always #5 clk = ~clk;

  mem_wb_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load_data(in_load_data), .in_alu_result(in_alu_result),
    .in_dest_reg(in_dest_reg), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_load_data(out_load_data), .out_alu_result(out_alu_result),
    .out_dest_reg(out_dest_reg), .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
`ifdef MEM_WB_FWD_EN
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
`endif
    .retire_count(retire_count)
  );

  typedef struct {
    logic [31:0] load, alu;
    logic [4:0]  dest;
    logic        rw;
    logic [1:0]  m2r;
  } beat_t;

  beat_t       q[$];
  logic [31:0] mCount = '0;
  int          vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the queue model.
  task automatic checkModel();
    logic mv;
    mv = (q.size() > 0);
    chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, mv && q[0].rw});
    chk("retire_count", retire_count, mCount);
    if (mv) begin
      chk("out_alu_result", out_alu_result, q[0].alu);
      chk("out_load_data", out_load_data, q[0].load);
      chk("out_dest_reg", {27'd0, out_dest_reg}, {27'd0, q[0].dest});
      chk("out_mem_to_reg", {30'd0, out_mem_to_reg}, {30'd0, q[0].m2r});
    end
`ifdef MEM_WB_FWD_EN
    begin
      logic live;
      live = mv && q[0].rw && (q[0].dest != 5'd0);
      chk("fwd_rs_hit", {31'd0, fwd_rs_hit}, {31'd0, live && q[0].dest == fwd_rs});
      chk("fwd_rt_hit", {31'd0, fwd_rt_hit}, {31'd0, live && q[0].dest == fwd_rt});
      if (mv) begin
        chk("fwd_rs_data", fwd_rs_data, (q[0].m2r == 2'd1) ? q[0].load : q[0].alu);
        chk("fwd_rt_data", fwd_rt_data, (q[0].m2r == 2'd1) ? q[0].load : q[0].alu);
      end
    end
`endif
  endtask

  // One clock: check, advance model with the beat presented this cycle.
  task automatic tick();
    logic acc, drn;
    beat_t b;
    #1;
    checkModel();
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    b = '{load: in_load_data, alu: in_alu_result, dest: in_dest_reg, rw: in_reg_write, m2r: in_mem_to_reg};
    @(posedge clk);
    if (drn) begin
      if (q[0].rw) mCount++;
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (acc) q.push_back(b);
    @(negedge clk);
  endtask

  task automatic setBeat(input logic v, input logic [31:0] alu, input logic [31:0] load,
                         input logic [4:0] dest, input logic rw, input logic [1:0] m2r);
    in_valid = v; in_alu_result = alu; in_load_data = load;
    in_dest_reg = dest; in_reg_write = rw; in_mem_to_reg = m2r;
  endtask

  task automatic doReset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    setBeat(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0);
    q.delete(); mCount = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    doReset();

    // Single beat: visible the cycle after accept, counted one edge later.
    out_ready = 1'b1;
    setBeat(1'b1, 32'h0000_00AA, 32'h0, 5'd3, 1'b1, 2'd0);
    tick();
    chk("t1 out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1 alu", out_alu_result, 32'h0000_00AA);
    chk("t1 dest", {27'd0, out_dest_reg}, 32'd3);
    in_valid = 1'b0;
    tick();
    chk("t1 retire", retire_count, 32'd1);

    // Back-to-back stream at full throughput.
    doReset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      setBeat(1'b1, 32'(i), 32'h0, 5'd7, 1'b1, 2'd0);
      tick();
      chk("t2 alu", out_alu_result, 32'(i));
      chk("t2 in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("t2 retire", retire_count, 32'd8);

    // Backpressure: fill skid, hold off third beat, then drain in order.
    doReset();
    setBeat(1'b1, 32'h11, 32'h0, 5'd1, 1'b1, 2'd0); tick();
    setBeat(1'b1, 32'h22, 32'h0, 5'd2, 1'b1, 2'd0); tick();
    chk("t3 in_ready full", {31'd0, in_ready}, 32'd0);
    setBeat(1'b1, 32'h33, 32'h0, 5'd3, 1'b1, 2'd0); tick();
    chk("t3 held", out_alu_result, 32'h11);
    out_ready = 1'b1;
    tick();
    chk("t3 second", out_alu_result, 32'h22);
    chk("t3 ready back", {31'd0, in_ready}, 32'd1);
    tick();
    chk("t3 third", out_alu_result, 32'h33);
    in_valid = 1'b0;
    tick();
    chk("t3 empty", {31'd0, out_valid}, 32'd0);
    chk("t3 retire", retire_count, 32'd3);

    // Flush while FULL with a concurrent accept attempt and drain.
    doReset();
    setBeat(1'b1, 32'h11, 32'h0, 5'd1, 1'b1, 2'd0); tick();
    setBeat(1'b1, 32'h22, 32'h0, 5'd2, 1'b1, 2'd0); tick();
    setBeat(1'b1, 32'h44, 32'h0, 5'd4, 1'b1, 2'd0);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4 out_valid", {31'd0, out_valid}, 32'd0);
    chk("t4 in_ready", {31'd0, in_ready}, 32'd1);
    chk("t4 retire", retire_count, 32'd1);
    tick(); tick();

    // Async reset mid-stream.
    doReset();
    out_ready = 1'b1;
    setBeat(1'b1, 32'h55, 32'h0, 5'd0, 1'b1, 2'd0); tick();
    setBeat(1'b1, 32'h66, 32'h0, 5'd9, 1'b1, 2'd0); tick();
    chk("t5 retire pre", retire_count, 32'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5 async reg_write", {31'd0, out_reg_write}, 32'd0);
    chk("t5 async retire", retire_count, 32'd0);
    chk("t5 async in_ready", {31'd0, in_ready}, 32'd1);
    doReset();

`ifdef MEM_WB_FWD_EN
    setBeat(1'b1, 32'h1234, 32'hDEAD_BEEF, 5'd5, 1'b1, 2'd1);
    fwd_rs = 5'd5; fwd_rt = 5'd0;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t6 rs_hit", {31'd0, fwd_rs_hit}, 32'd1);
    chk("t6 rs_data", fwd_rs_data, 32'hDEAD_BEEF);
    chk("t6 rt_hit", {31'd0, fwd_rt_hit}, 32'd0);
    doReset();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      setBeat($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
              1'($urandom), 2'($urandom_range(0, 3)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
`ifdef MEM_WB_FWD_EN
      fwd_rs = 5'($urandom_range(0, 31));
      fwd_rt = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0].dest : 5'($urandom_range(0, 31));
`endif
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
